load_store_unit: RTL

Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register. It issues each data-memory access on a req/ack bus and stalls the pipeline until the access completes. It formats store data and byte strobes, and extracts, sign-extends or zero-extends load data. The result is presented as the read-data value latched into MEM/WB.

---
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues one data-memory access per instruction on a
// req/ack bus, stalls the pipeline while it waits, and formats store and load data.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  Funct3_in,
    input  logic [31:0] Addr_in,
    input  logic [31:0] StoreData_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadData_out,
    output logic        stall_out,
    output logic        done_out,
    output logic        fault_out
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             fault_q;
    logic [1:0]       lat_off;
    logic [2:0]       lat_funct3;

    logic             access_c;
    logic             legal_c;
    logic             aligned_c;
    logic             accept_c;
    logic             reject_c;
    logic             timeout_c;
    logic [31:0]      st_wdata_c;
    logic [3:0]       st_wstrb_c;
    logic [7:0]       ld_byte_c;
    logic [15:0]      ld_half_c;
    logic [31:0]      ld_data_c;

    // Request decode: legality of funct3 for the access kind and natural alignment.
    always_comb begin
        access_c  = valid_in && (MemRead_in || MemWrite_in);
        legal_c   = 1'b0;
        aligned_c = 1'b1;
        case (Funct3_in)
            3'b000, 3'b001, 3'b010: legal_c = 1'b1;
            3'b100, 3'b101:         legal_c = !MemWrite_in;
            default:                legal_c = 1'b0;
        endcase
        case (Funct3_in[1:0])
            2'b01:   aligned_c = !Addr_in[0];
            2'b10:   aligned_c = (Addr_in[1:0] == 2'b00);
            default: aligned_c = 1'b1;
        endcase
        accept_c  = access_c && legal_c && aligned_c;
        reject_c  = access_c && !(legal_c && aligned_c);
        timeout_c = (TIMEOUT_CYCLES != 0) && ((wait_cnt + CNT_W'(1)) == CNT_LAST);
    end

    // Store data is replicated across lanes; strobes pick the addressed lane(s).
    always_comb begin
        st_wdata_c = StoreData_in;
        st_wstrb_c = 4'b1111;
        case (Funct3_in[1:0])
            2'b00: begin
                st_wdata_c = {4{StoreData_in[7:0]}};
                st_wstrb_c = 4'b0001 << Addr_in[1:0];
            end
            2'b01: begin
                st_wdata_c = {2{StoreData_in[15:0]}};
                st_wstrb_c = 4'b0011 << {Addr_in[1], 1'b0};
            end
            default: begin
                st_wdata_c = StoreData_in;
                st_wstrb_c = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and extension, driven by the latched offset and size.
    always_comb begin
        ld_byte_c = mem_rdata[7:0];
        case (lat_off)
            2'd0:    ld_byte_c = mem_rdata[7:0];
            2'd1:    ld_byte_c = mem_rdata[15:8];
            2'd2:    ld_byte_c = mem_rdata[23:16];
            default: ld_byte_c = mem_rdata[31:24];
        endcase
        ld_half_c = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_funct3)
            3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
            3'b100:  ld_data_c = {24'd0, ld_byte_c};
            3'b101:  ld_data_c = {16'd0, ld_half_c};
            default: ld_data_c = mem_rdata;
        endcase
    end

    // Pipeline handshake: stall while accepting or waiting, fault on reject or timeout.
    always_comb begin
        stall_out = !reset && (((state == IDLE) && accept_c) || (state == BUSY));
        fault_out = !reset && (((state == IDLE) && reject_c) || ((state == RESP) && fault_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            fault_q      <= 1'b0;
            lat_off      <= 2'd0;
            lat_funct3   <= 3'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_wstrb    <= 4'd0;
            ReadData_out <= 32'd0;
            done_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state      <= BUSY;
                        wait_cnt   <= '0;
                        fault_q    <= 1'b0;
                        lat_off    <= Addr_in[1:0];
                        lat_funct3 <= Funct3_in;
                        mem_req    <= 1'b1;
                        mem_we     <= MemWrite_in;
                        mem_addr   <= {Addr_in[31:2], 2'b00};
                        mem_wdata  <= MemWrite_in ? st_wdata_c : 32'd0;
                        mem_wstrb  <= MemWrite_in ? st_wstrb_c : 4'd0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        done_out <= 1'b1;
                        if (!mem_we) begin
                            ReadData_out <= ld_data_c;
                        end
                    end else if (timeout_c) begin
                        state        <= RESP;
                        mem_req      <= 1'b0;
                        done_out     <= 1'b1;
                        fault_q      <= 1'b1;
                        ReadData_out <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    done_out <= 1'b0;
                    fault_q  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mem_req  <= 1'b0;
                    done_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
